fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Consumer end of the control unit's BranchOp/Jump interface. Owns the PC and fetches each instruction
//  from instruction memory over a req/ack handshake, then presents it to decode/execute. It waits for
//  execute to resolve branch or jump, computes the next PC, and repeats. Sits between imem and CU/datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC after reset; bits [1:0] must be 2'b00
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  imem_req      out  1   fetch request; held high until imem_ack
//  imem_addr     out  32  fetch address (= pc), stable while imem_req
//  imem_ack      in   1   imem_rdata valid this cycle; may coincide with first req cycle
//  imem_rdata    in   32  fetched instruction word
//  instr         out  32  registered instruction for decode (OP_Code = instr[31:26])
//  instr_valid   out  1   instr valid; high for the whole EXEC state
//  pc            out  32  address of current instruction
//  ex_done       in   1   execute finished; branch inputs below valid this cycle
//  BranchOp      in   3   from CU: 000 none,001 beq,010 bgez,011 bgtz,100 blez,101 bne
//  Jump          in   1   from CU: unconditional jump
//  rs_val        in   32  register rs value
//  rt_val        in   32  register rt value
//  imm16         in   16  instr[15:0] branch offset (words)
//  jidx          in   26  instr[25:0] jump index
//  branch_taken  out  1   registered; 1 for one cycle after ex_done if PC redirected
// BEHAVIOUR
//  - Reset (async): state=REQ, pc=RESET_PC, instr=0, instr_valid=0, branch_taken=0.
//    imem_req rises in the first cycle after rst deasserts.
//  - FSM states: REQ, EXEC.
//    REQ: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, go to EXEC (1 cycle if zero-wait).
//    EXEC: imem_req=0, instr_valid=1. On ex_done: pc<=next_pc, branch_taken<=taken, go to REQ.
//  - imem_ack outside REQ is ignored. ex_done outside EXEC is ignored. Inputs are sampled only on ex_done.
//  - branch_taken is cleared on every clock edge where it is not being set.
//  - pc4 = pc + 4. btgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00}. jtgt = {pc4[31:28], jidx, 2'b00}.
//    All adds are 32-bit modulo; wrap at 32'hFFFF_FFFC -> 0 is legal.
//  - Condition: beq rs==rt; bne rs!=rt; bgez !rs[31]; bgtz !rs[31] && rs!=0; blez rs[31] || rs==0.
//    All are signed compares on rs_val. BranchOp 110/111 are reserved and not taken.
//  - next_pc priority: Jump=1 -> jtgt (BranchOp ignored, even if X); else cond true -> btgt; else pc4.
//  - taken = Jump | cond.
//  - pc[1:0] is always 00. A branch to self (imm16=16'hFFFF) is legal and refetches the same address.
//  - Reset mid-handshake abandons the request. imem shares rst, so no stale ack arrives after reset.
//  - Throughput: at most one instruction per 2 cycles (REQ+EXEC) with zero-wait imem and same-cycle ex_done.
// STRUCTURE
//  - Shared package mips_pkg: BranchOp encodings (BR_NONE..BR_BNE), opcode constants shared with the
//    control unit, default RESET_PC, and state encoding localparams.
//  - One sub-module: branch_cond (combinational; inputs BranchOp, rs_val, rt_val; output cond).
//    next_pc mux, FSM and registers live in fetch_pc_unit.
// TESTING
//  1. Reset while in EXEC -> pc=0, instr_valid=0, branch_taken=0 asynchronously; req high next cycle, addr 0.
//  2. Zero-wait imem, ex_done same cycle as EXEC entry, BranchOp=000 -> addresses 0,4,8, one fetch per 2 cycles.
//  3. ack delayed 3 cycles -> imem_req/imem_addr stable 4 cycles; instr latched only on ack; spurious ack in EXEC ignored.
//  4. pc=0x100, beq, rs=rt=5, imm16=0xFFFE -> next fetch 0xFC, branch_taken pulses once.
//     Same case with bne -> 0x104, taken=0.
//  5. bgez/bgtz/blez with rs = 0, 1, 0x8000_0000 -> taken pattern (1,0,1), (1,1,0), (0,0,1).
//  6. pc=0x1000_0000, Jump=1, BranchOp=X, jidx=0x3FF_FFFF -> 0x1FFF_FFFC.
//     pc=0xFFFF_FFFC, no branch -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the control unit, fetch unit and datapath.
// Branch ops, opcodes, default reset PC and fetch FSM state encodings.
package mips_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BGEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLEZ = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic ST_REQ_ENC  = 1'b0;
    localparam logic ST_EXEC_ENC = 1'b1;

    typedef enum logic {
        ST_REQ  = ST_REQ_ENC,
        ST_EXEC = ST_EXEC_ENC
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction memory req/ack fetch channel.
// master = fetch unit, slave = instruction memory.
interface fetch_pc_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_unit_branch_cond.sv
// branch_cond: evaluates the CU branch condition on rs/rt.
// Reserved BranchOp codes (and unknown codes) are never taken.
module branch_cond
    import mips_pkg::*;
(
    input  logic [2:0]  BranchOp,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        cond
);

    logic rs_eq_rt;
    logic rs_zero;
    logic rs_neg;

    assign rs_eq_rt = (rs_val == rt_val);
    assign rs_zero  = (rs_val == 32'd0);
    assign rs_neg   = rs_val[31];

    // select the signed test for the requested branch op
    always_comb begin
        cond = 1'b0;
        case (BranchOp)
            BR_BEQ:  cond = rs_eq_rt;
            BR_BNE:  cond = !rs_eq_rt;
            BR_BGEZ: cond = !rs_neg;
            BR_BGTZ: cond = !rs_neg && !rs_zero;
            BR_BLEZ: cond = rs_neg || rs_zero;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, fetches over imem req/ack and
// redirects on branch/jump once execute reports ex_done.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_unit_if.master imem,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   pc,
    input  logic          ex_done,
    input  logic [2:0]    BranchOp,
    input  logic          Jump,
    input  logic [31:0]   rs_val,
    input  logic [31:0]   rt_val,
    input  logic [15:0]   imm16,
    input  logic [25:0]   jidx,
    output logic          branch_taken
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic        cond;
    logic        taken;
    logic [31:0] pc4;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [31:0] next_pc;

    branch_cond u_cond (
        .BranchOp (BranchOp),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .cond     (cond)
    );

    assign pc4  = pc + 32'd4;
    assign btgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jtgt = {pc4[31:28], jidx, 2'b00};

    // jump wins over any branch op, so BranchOp is don't-care on Jump
    always_comb begin
        next_pc = pc4;
        if (Jump) begin
            next_pc = jtgt;
        end else if (cond) begin
            next_pc = btgt;
        end
    end

    assign taken          = Jump | cond;
    assign imem.imem_addr = pc;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake outputs; req held off while in reset
    always_comb begin
        state_nxt     = state;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        unique case (state)
            ST_REQ: begin
                imem.imem_req = !rst;
                if (imem.imem_ack) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (ex_done) begin
                    state_nxt = ST_REQ;
                end
            end
        endcase
    end

    // pc, instruction latch and one-cycle taken pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= {RESET_PC[31:2], 2'b00};
            instr        <= 32'd0;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            if (state == ST_REQ && imem.imem_ack) begin
                instr <= imem.imem_rdata;
            end
            if (state == ST_EXEC && ex_done) begin
                pc           <= next_pc;
                branch_taken <= taken;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for the fetch/PC unit.
// Expected fetch addresses and taken flags are queued at ex_done.
module tb_fetch_pc_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        ex_done;
    logic [2:0]  BranchOp;
    logic        Jump;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic        branch_taken;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (bus),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .ex_done      (ex_done),
        .BranchOp     (BranchOp),
        .Jump         (Jump),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .imm16        (imm16),
        .jidx         (jidx),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk  = 0;
    int npass = 0;

    logic [31:0] q_addr[$];
    logic        q_tkn[$];
    logic [31:0] model_pc;

    function automatic logic [31:0] model_next(
        input logic [31:0] p, input logic [2:0] op, input logic j,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [15:0] imm, input logic [25:0] ji, output logic tk);
        logic        c;
        logic [31:0] p4;
        logic [31:0] off;
        p4  = p + 32'd4;
        off = {{16{imm[15]}}, imm} << 2;
        case (op)
            3'd1:    c = (rs == rt);
            3'd2:    c = ($signed(rs) >= 0);
            3'd3:    c = ($signed(rs) > 0);
            3'd4:    c = ($signed(rs) <= 0);
            3'd5:    c = (rs != rt);
            default: c = 1'b0;
        endcase
        if (j) begin
            tk = 1'b1;
            return {p4[31:28], ji, 2'b00};
        end
        tk = c;
        return c ? p4 + off : p4;
    endfunction

    task automatic hold_rst;
        rst             = 1'b1;
        ex_done         = 1'b0;
        Jump            = 1'b0;
        BranchOp        = 3'b000;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
    endtask

    task automatic release_rst(output int c0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c0  = cyc;
        q_addr.delete();
        q_tkn.delete();
        model_pc = 32'h0;
        q_addr.push_back(32'h0);
    endtask

    task automatic serve_fetch(input int dly, input logic [31:0] word,
        output logic [31:0] addr, output int held, output int seen,
        output logic [31:0] instr_pre);
        bit ok = 1'b0;
        held      = 0;
        seen      = -1;
        addr      = 'x;
        instr_pre = instr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.imem_req;
        end
        if (!ok) return;
        addr = bus.imem_addr;
        held = 1;
        seen = cyc;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_addr === addr) held++;
        end
        instr_pre      = instr;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic exec_step(input logic [2:0] op, input logic j,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [15:0] imm, input logic [25:0] ji, output logic tk_obs);
        logic        tk;
        logic [31:0] nx;
        nx = model_next(model_pc, op, j, rs, rt, imm, ji, tk);
        q_addr.push_back(nx);
        q_tkn.push_back(tk);
        model_pc = nx;
        BranchOp = op;
        Jump     = j;
        rs_val   = rs;
        rt_val   = rt;
        imm16    = imm;
        jidx     = ji;
        ex_done  = 1'b1;
        @(posedge clk);
        #1;
        ex_done  = 1'b0;
        BranchOp = 3'b000;
        Jump     = 1'b0;
        tk_obs   = branch_taken;
    endtask

    task automatic test_reset;
        logic [31:0] a, e, ip;
        int h, c, c0;
        logic tk, et;
        hold_rst();
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 ||
            branch_taken !== 1'b0 || instr !== 32'h0)
            $display("FAIL reset_state: req=%b iv=%b pc=%h bt=%b instr=%h, expected all zero",
                     bus.imem_req, instr_valid, pc, branch_taken, instr);
        else npass++;
        release_rst(c0);
        serve_fetch(0, 32'h2000_0001, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== e || c !== c0 + 1)
            $display("FAIL first_req: addr %h cyc %0d, expected %h cyc %0d", a, c, e, c0 + 1);
        else npass++;
        exec_step(BR_NONE, 1'b1, 32'h0, 32'h0, 16'h0, 26'h40, tk);
        et = q_tkn.pop_front();
        nchk++;
        if (tk !== et) $display("FAIL jump_taken: got %b, expected %b", tk, et);
        else npass++;
        rst = 1'b1;
        #1;
        nchk++;
        if (branch_taken !== 1'b0 || pc !== 32'h0 || bus.imem_req !== 1'b0)
            $display("FAIL async_rst_req: bt=%b pc=%h req=%b, expected 0 0 0",
                     branch_taken, pc, bus.imem_req);
        else npass++;
        hold_rst();
        release_rst(c0);
        serve_fetch(0, 32'h2000_0002, a, h, c, ip);
        void'(q_addr.pop_front());
        exec_step(BR_NONE, 1'b1, 32'h0, 32'h0, 16'h0, 26'h40, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h2000_0003, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== e || instr_valid !== 1'b1 || instr !== 32'h2000_0003)
            $display("FAIL exec_entry: addr %h iv %b instr %h, expected %h 1 20000003",
                     a, instr_valid, instr, e);
        else npass++;
        #2;
        rst = 1'b1;
        #1;
        nchk++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || branch_taken !== 1'b0)
            $display("FAIL async_rst_exec: pc %h iv %b instr %h bt %b, expected 0 0 0 0",
                     pc, instr_valid, instr, branch_taken);
        else npass++;
        hold_rst();
        release_rst(c0);
        serve_fetch(0, 32'h2000_0004, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h0 || a !== e || c !== c0 + 1)
            $display("FAIL refetch_after_rst: addr %h cyc %0d, expected 0 cyc %0d", a, c, c0 + 1);
        else npass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, e, ip, w;
        int h, c, prev, c0;
        logic tk, et;
        hold_rst();
        release_rst(c0);
        serve_fetch(0, 32'h1000_0000, a, h, prev, ip);
        void'(q_addr.pop_front());
        for (int k = 1; k <= 3; k++) begin
            exec_step(BR_NONE, 1'b0, 32'h0, 32'h1, 16'h0, 26'h0, tk);
            et = q_tkn.pop_front();
            w  = 32'h1000_0000 + k;
            serve_fetch(0, w, a, h, c, ip);
            e  = q_addr.pop_front();
            nchk++;
            if (a !== e || a !== 32'(4 * k) || tk !== et || tk !== 1'b0 || c - prev !== 2 ||
                instr !== w)
                $display("FAIL seq_fetch%0d: addr %h tk %b gap %0d instr %h, expected %h 0 2 %h",
                         k, a, tk, c - prev, instr, e, w);
            else npass++;
            prev = c;
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] a, e, ip, old;
        int h, c;
        logic tk;
        old = instr;
        exec_step(BR_NONE, 1'b0, 32'h0, 32'h0, 16'h0, 26'h0, tk);
        void'(q_tkn.pop_front());
        serve_fetch(3, 32'hCAFE_0010, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== e || h !== 4)
            $display("FAIL wait_hold: addr %h held %0d, expected %h held 4", a, h, e);
        else npass++;
        nchk++;
        if (ip !== old || instr !== 32'hCAFE_0010)
            $display("FAIL wait_latch: before %h after %h, expected %h then cafe0010",
                     ip, instr, old);
        else npass++;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b0;
        nchk++;
        if (instr !== 32'hCAFE_0010 || instr_valid !== 1'b1 || bus.imem_req !== 1'b0)
            $display("FAIL spurious_ack: instr %h iv %b req %b, expected cafe0010 1 0",
                     instr, instr_valid, bus.imem_req);
        else npass++;
    endtask

    task automatic test_branch;
        logic [31:0] a, e, ip;
        int h, c;
        logic tk, et;
        exec_step(BR_NONE, 1'b1, 32'h0, 32'h0, 16'h0, 26'h40, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h1000_FFFE, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h100 || a !== e) $display("FAIL jump_0x100: addr %h, expected 100", a);
        else npass++;
        exec_step(BR_BEQ, 1'b0, 32'd5, 32'd5, 16'hFFFE, 26'h0, tk);
        et = q_tkn.pop_front();
        nchk++;
        if (tk !== 1'b1 || tk !== et) $display("FAIL beq_taken: got %b, expected 1", tk);
        else npass++;
        @(posedge clk);
        #1;
        nchk++;
        if (branch_taken !== 1'b0) $display("FAIL taken_pulse: got %b, expected 0", branch_taken);
        else npass++;
        serve_fetch(0, 32'h0800_0040, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'hFC || a !== e) $display("FAIL beq_target: addr %h, expected fc", a);
        else npass++;
        exec_step(BR_NONE, 1'b1, 32'h0, 32'h0, 16'h0, 26'h40, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h1400_0001, a, h, c, ip);
        void'(q_addr.pop_front());
        exec_step(BR_BNE, 1'b0, 32'd5, 32'd5, 16'hFFFE, 26'h0, tk);
        et = q_tkn.pop_front();
        serve_fetch(0, 32'h1000_FFFF, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h104 || a !== e || tk !== 1'b0 || tk !== et)
            $display("FAIL bne_fallthru: addr %h tk %b, expected 104 0", a, tk);
        else npass++;
        exec_step(BR_BEQ, 1'b0, 32'd7, 32'd7, 16'hFFFF, 26'h0, tk);
        et = q_tkn.pop_front();
        serve_fetch(0, 32'h1000_0001, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h104 || a !== e || tk !== 1'b1 || tk !== et)
            $display("FAIL branch_self: addr %h tk %b, expected 104 1", a, tk);
        else npass++;
    endtask

    task automatic test_cond;
        logic [31:0] a, e, ip;
        logic [31:0] rs_tab[3];
        logic [2:0]  op_tab[3];
        logic [2:0]  exp_tab[3];
        int h, c;
        logic tk, et;
        rs_tab  = '{32'h0, 32'h1, 32'h8000_0000};
        op_tab  = '{BR_BGEZ, BR_BGTZ, BR_BLEZ};
        exp_tab = '{3'b101, 3'b110, 3'b001};
        for (int r = 0; r < 3; r++) begin
            for (int o = 0; o < 3; o++) begin
                exec_step(op_tab[o], 1'b0, rs_tab[r], 32'h0, 16'h0010, 26'h0, tk);
                et = q_tkn.pop_front();
                serve_fetch(0, 32'h0, a, h, c, ip);
                e = q_addr.pop_front();
                nchk++;
                if (tk !== exp_tab[r][2 - o] || tk !== et || a !== e)
                    $display("FAIL cond_op%0d_rs%h: tk %b addr %h, expected %b %h",
                             op_tab[o], rs_tab[r], tk, a, exp_tab[r][2 - o], e);
                else npass++;
            end
        end
    endtask

    task automatic test_jump_wrap;
        logic [31:0] a, e, ip;
        int h, c, c0;
        logic tk, et;
        exec_step(BR_NONE, 1'b1, 32'h0, 32'h0, 16'h0, 26'h3FF_FFFF, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h0, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h0FFF_FFFC || a !== e) $display("FAIL jump_max: addr %h, expected 0ffffffc", a);
        else npass++;
        exec_step(BR_NONE, 1'b0, 32'h0, 32'h0, 16'h0, 26'h0, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h0, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h1000_0000 || a !== e) $display("FAIL region_cross: addr %h, expected 10000000", a);
        else npass++;
        exec_step(3'bxxx, 1'b1, 32'h0, 32'h1, 16'h0, 26'h3FF_FFFF, tk);
        et = q_tkn.pop_front();
        serve_fetch(0, 32'h0, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h1FFF_FFFC || a !== e || tk !== 1'b1 || tk !== et)
            $display("FAIL jump_x_op: addr %h tk %b, expected 1ffffffc 1", a, tk);
        else npass++;
        hold_rst();
        release_rst(c0);
        serve_fetch(0, 32'h0, a, h, c, ip);
        void'(q_addr.pop_front());
        exec_step(BR_BEQ, 1'b0, 32'h3, 32'h3, 16'hFFFE, 26'h0, tk);
        void'(q_tkn.pop_front());
        serve_fetch(0, 32'h0, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'hFFFF_FFFC || a !== e) $display("FAIL branch_neg_wrap: addr %h, expected fffffffc", a);
        else npass++;
        exec_step(BR_NONE, 1'b0, 32'h0, 32'h0, 16'h0, 26'h0, tk);
        et = q_tkn.pop_front();
        serve_fetch(0, 32'h0, a, h, c, ip);
        e = q_addr.pop_front();
        nchk++;
        if (a !== 32'h0 || a !== e || tk !== 1'b0 || tk !== et)
            $display("FAIL pc_wrap: addr %h tk %b, expected 0 0", a, tk);
        else npass++;
    endtask

    initial begin
        rs_val = 32'h0;
        rt_val = 32'h0;
        imm16  = 16'h0;
        jidx   = 26'h0;
        hold_rst();
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_branch();
        test_cond();
        test_jump_wrap();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
